// File: rtl/context_sequencer.sv
// Job-level context FSM for the systolic-array context switch path.
// Ports: i_start/i_abort/i_n_ctx/i_incntlim_cfg job control; i_stall, i_cdone,
//   i_cswitch_done status; o_clear/o_incntlim/o_pipeline_en/o_cswitch_en/
//   o_cswitch_force drive the switch controller; o_ctx_idx/o_busy/o_done/o_err.
module context_sequencer #(
    parameter int IDX_W     = 11,
    parameter int CTX_W     = 16,
    parameter int FLUSH_MAX = 64
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [CTX_W-1:0] i_n_ctx,
    input  logic [IDX_W-1:0] i_incntlim_cfg,
    input  logic             i_stall,
    input  logic             i_cdone,
    input  logic             i_cswitch_done,
    output logic             o_clear,
    output logic [IDX_W-1:0] o_incntlim,
    output logic             o_pipeline_en,
    output logic             o_cswitch_en,
    output logic             o_cswitch_force,
    output logic [CTX_W-1:0] o_ctx_idx,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    localparam int FC_W = $clog2(FLUSH_MAX) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CTX_W-1:0]  r_n_ctx;
    logic [IDX_W-1:0]  r_incntlim;
    logic [CTX_W-1:0]  r_ctx_cnt;
    logic [1:0]        r_pend;
    logic [FC_W-1:0]   r_flush_cnt;
    logic              r_abort_clr;
    logic              r_err;
    logic              w_accept;
    logic              w_dec;
    logic              w_sw_last;
    logic              w_flush_to;
    logic              w_last_cdone;

    assign w_accept     = (r_state == S_IDLE) && i_start && !i_abort;
    assign w_dec        = i_cswitch_done && (r_pend != 2'd0);
    // Final switch-out finished: no switch outstanding, or this pulse retires the last one.
    assign w_sw_last    = (r_pend == 2'd0) || (i_cswitch_done && r_pend == 2'd1);
    assign w_flush_to   = !w_sw_last && (r_flush_cnt == FC_W'(FLUSH_MAX - 1));
    assign w_last_cdone = i_cdone && (r_ctx_cnt == r_n_ctx - CTX_W'(1));

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_CLEAR;
            S_CLEAR: w_state_nxt = (r_n_ctx == '0) ? S_DONE : S_RUN;
            S_RUN:   if (w_last_cdone) w_state_nxt = S_FLUSH;
            S_FLUSH: if (w_sw_last || w_flush_to) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (i_abort) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state     <= S_IDLE;
            r_n_ctx     <= '0;
            r_incntlim  <= '0;
            r_ctx_cnt   <= '0;
            r_pend      <= '0;
            r_flush_cnt <= '0;
            r_abort_clr <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_abort_clr <= i_abort;
            r_flush_cnt <= (r_state == S_FLUSH && !i_abort) ?
                           r_flush_cnt + FC_W'(1) : '0;
            if (i_abort) begin
                r_pend <= '0;
            end else if (w_accept) begin
                r_n_ctx    <= i_n_ctx;
                r_incntlim <= i_incntlim_cfg;
                r_ctx_cnt  <= '0;
                r_pend     <= '0;
                r_err      <= 1'b0;
            end else if (r_state == S_RUN) begin
                if (i_cdone) r_ctx_cnt <= r_ctx_cnt + CTX_W'(1);
                if (i_cdone && !w_dec) begin
                    // Saturate: a fourth outstanding switch is an error.
                    if (r_pend == 2'd3) r_err <= 1'b1;
                    else r_pend <= r_pend + 2'd1;
                end else if (w_dec && !i_cdone) begin
                    r_pend <= r_pend - 2'd1;
                end
            end else if (r_state == S_FLUSH) begin
                if (w_dec) r_pend <= r_pend - 2'd1;
                if (w_flush_to) r_err <= 1'b1;
            end
        end
    end

    assign o_clear         = (r_state == S_CLEAR) || r_abort_clr;
    assign o_incntlim      = r_incntlim;
    assign o_pipeline_en   = (r_state == S_FLUSH) || ((r_state == S_RUN) && !i_stall);
    assign o_cswitch_en    = (r_state == S_RUN) || (r_state == S_FLUSH);
    assign o_cswitch_force = (r_state == S_FLUSH);
    assign o_ctx_idx       = r_ctx_cnt;
    assign o_busy          = (r_state != S_IDLE);
    assign o_done          = (r_state == S_DONE);
    assign o_err           = r_err;

endmodule

// File: tb/tb_context_sequencer.sv
// Directed self-checking bench for context_sequencer.
// Each scenario task drives stimulus and compares outputs inline.
module tb_context_sequencer;

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic [15:0] i_n_ctx = '0;
    logic [10:0] i_incntlim_cfg = '0;
    logic        i_stall = 1'b0;
    logic        i_cdone = 1'b0;
    logic        i_cswitch_done = 1'b0;
    logic        o_clear;
    logic [10:0] o_incntlim;
    logic        o_pipeline_en;
    logic        o_cswitch_en;
    logic        o_cswitch_force;
    logic [15:0] o_ctx_idx;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 i_clk = ~i_clk;

    context_sequencer dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_abort(i_abort),
        .i_n_ctx(i_n_ctx), .i_incntlim_cfg(i_incntlim_cfg), .i_stall(i_stall),
        .i_cdone(i_cdone), .i_cswitch_done(i_cswitch_done), .o_clear(o_clear),
        .o_incntlim(o_incntlim), .o_pipeline_en(o_pipeline_en),
        .o_cswitch_en(o_cswitch_en), .o_cswitch_force(o_cswitch_force),
        .o_ctx_idx(o_ctx_idx), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic start_job(input logic [15:0] n, input logic [10:0] lim);
        i_n_ctx = n;
        i_incntlim_cfg = lim;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    task automatic pulse(input logic cd, input logic sd);
        i_cdone = cd;
        i_cswitch_done = sd;
        step();
        i_cdone = 1'b0;
        i_cswitch_done = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({o_clear, o_pipeline_en, o_cswitch_en, o_cswitch_force, o_busy,
             o_done, o_err} !== 7'b0 || o_incntlim !== 11'd0 || o_ctx_idx !== 16'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: flags=%b lim=%0d idx=%0d, required all 0",
                {o_clear, o_pipeline_en, o_cswitch_en, o_cswitch_force, o_busy,
                 o_done, o_err}, o_incntlim, o_ctx_idx);
        end
        i_rstn = 1'b1;
        step();
        n_checks++;
        if (o_busy !== 1'b0 || o_clear !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle: busy=%b clear=%b, required 0 0", o_busy, o_clear);
        end
    endtask

    task automatic test_normal_job();
        int dones;
        logic [15:0] e_idx;
        logic e_force, e_en, e_done, e_busy;
        dones = 0;
        start_job(16'd3, 11'd4);
        n_checks++;
        if (o_clear !== 1'b1 || o_incntlim !== 11'd4 || o_busy !== 1'b1 ||
            o_pipeline_en !== 1'b0) begin
            n_errors++;
            $display("FAIL normal_clear: clear=%b lim=%0d busy=%b pen=%b, required 1 4 1 0",
                o_clear, o_incntlim, o_busy, o_pipeline_en);
        end
        step();
        n_checks++;
        if (o_clear !== 1'b0 || o_pipeline_en !== 1'b1 || o_cswitch_en !== 1'b1 ||
            o_cswitch_force !== 1'b0) begin
            n_errors++;
            $display("FAIL normal_run_entry: clear=%b pen=%b cen=%b force=%b, required 0 1 1 0",
                o_clear, o_pipeline_en, o_cswitch_en, o_cswitch_force);
        end
        for (int c = 1; c <= 30; c++) begin
            pulse(c == 6 || c == 12 || c == 18, c == 14 || c == 20 || c == 26);
            e_idx   = (c >= 18) ? 16'd3 : (c >= 12) ? 16'd2 : (c >= 6) ? 16'd1 : 16'd0;
            e_force = (c >= 18) && (c < 26);
            e_en    = (c < 26);
            e_done  = (c == 26);
            e_busy  = (c < 27);
            if (o_done) dones++;
            n_checks++;
            if (o_ctx_idx !== e_idx || o_cswitch_force !== e_force ||
                o_pipeline_en !== e_en || o_cswitch_en !== e_en ||
                o_done !== e_done || o_busy !== e_busy) begin
                n_errors++;
                $display("FAIL normal_cyc%0d: idx=%0d f=%b pen=%b cen=%b d=%b b=%b, required %0d %b %b %b %b %b",
                    c, o_ctx_idx, o_cswitch_force, o_pipeline_en, o_cswitch_en, o_done,
                    o_busy, e_idx, e_force, e_en, e_en, e_done, e_busy);
            end
        end
        n_checks++;
        if (dones !== 1 || o_err !== 1'b0) begin
            n_errors++;
            $display("FAIL normal_done_count: dones=%0d err=%b, required 1 0", dones, o_err);
        end
    endtask

    task automatic test_zero_ctx();
        start_job(16'd0, 11'd7);
        n_checks++;
        if (o_clear !== 1'b1 || o_pipeline_en !== 1'b0 || o_done !== 1'b0) begin
            n_errors++;
            $display("FAIL zero_clear: clear=%b pen=%b done=%b, required 1 0 0",
                o_clear, o_pipeline_en, o_done);
        end
        step();
        n_checks++;
        if (o_done !== 1'b1 || o_clear !== 1'b0 || o_pipeline_en !== 1'b0 ||
            o_cswitch_en !== 1'b0) begin
            n_errors++;
            $display("FAIL zero_done: done=%b clear=%b pen=%b cen=%b, required 1 0 0 0",
                o_done, o_clear, o_pipeline_en, o_cswitch_en);
        end
        step();
        n_checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_pipeline_en !== 1'b0) begin
            n_errors++;
            $display("FAIL zero_idle: done=%b busy=%b pen=%b, required 0 0 0",
                o_done, o_busy, o_pipeline_en);
        end
    endtask

    task automatic test_stall();
        int low;
        low = 0;
        start_job(16'd2, 11'd4);
        step();
        for (int k = 0; k < 5; k++) begin
            i_stall = 1'b1;
            #1;
            if (o_pipeline_en === 1'b0 && o_cswitch_en === 1'b1) low++;
            step();
        end
        i_stall = 1'b0;
        #1;
        n_checks++;
        if (low !== 5 || o_pipeline_en !== 1'b1) begin
            n_errors++;
            $display("FAIL stall_run: low_cycles=%0d pen_after=%b, required 5 1",
                low, o_pipeline_en);
        end
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        i_stall = 1'b1;
        #1;
        n_checks++;
        if (o_pipeline_en !== 1'b1 || o_cswitch_force !== 1'b1 || o_ctx_idx !== 16'd2) begin
            n_errors++;
            $display("FAIL stall_flush: pen=%b force=%b idx=%0d, required 1 1 2",
                o_pipeline_en, o_cswitch_force, o_ctx_idx);
        end
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        i_stall = 1'b0;
        n_checks++;
        if (o_done !== 1'b1 || o_pipeline_en !== 1'b0) begin
            n_errors++;
            $display("FAIL stall_done: done=%b pen=%b, required 1 0", o_done, o_pipeline_en);
        end
        step();
    endtask

    task automatic test_same_cycle();
        start_job(16'd3, 11'd2);
        step();
        pulse(1'b1, 1'b0);
        i_n_ctx = 16'd9;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        n_checks++;
        if (o_clear !== 1'b0 || o_pipeline_en !== 1'b1 || o_ctx_idx !== 16'd1) begin
            n_errors++;
            $display("FAIL ignore_start: clear=%b pen=%b idx=%0d, required 0 1 1",
                o_clear, o_pipeline_en, o_ctx_idx);
        end
        pulse(1'b1, 1'b1);
        n_checks++;
        if (o_ctx_idx !== 16'd2 || o_cswitch_force !== 1'b0) begin
            n_errors++;
            $display("FAIL same_cycle_idx: idx=%0d force=%b, required 2 0",
                o_ctx_idx, o_cswitch_force);
        end
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        n_checks++;
        if (o_cswitch_force !== 1'b1 || o_done !== 1'b0 || o_ctx_idx !== 16'd3) begin
            n_errors++;
            $display("FAIL same_cycle_pend: force=%b done=%b idx=%0d, required 1 0 3",
                o_cswitch_force, o_done, o_ctx_idx);
        end
        pulse(1'b0, 1'b1);
        n_checks++;
        if (o_done !== 1'b1) begin
            n_errors++;
            $display("FAIL same_cycle_done: done=%b, required 1", o_done);
        end
        pulse(1'b1, 1'b0);
        n_checks++;
        if (o_ctx_idx !== 16'd3 || o_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL cdone_idle: idx=%0d busy=%b, required 3 0", o_ctx_idx, o_busy);
        end
    endtask

    task automatic test_pend_overflow();
        start_job(16'd5, 11'd1);
        step();
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        n_checks++;
        if (o_err !== 1'b0) begin
            n_errors++;
            $display("FAIL pend_three: err=%b, required 0", o_err);
        end
        pulse(1'b1, 1'b0);
        n_checks++;
        if (o_err !== 1'b1 || o_ctx_idx !== 16'd4) begin
            n_errors++;
            $display("FAIL pend_overflow: err=%b idx=%0d, required 1 4", o_err, o_ctx_idx);
        end
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        n_checks++;
        if (o_cswitch_force !== 1'b1 || o_done !== 1'b0) begin
            n_errors++;
            $display("FAIL pend_saturated: force=%b done=%b, required 1 0",
                o_cswitch_force, o_done);
        end
        pulse(1'b0, 1'b1);
        n_checks++;
        if (o_done !== 1'b1 || o_err !== 1'b1) begin
            n_errors++;
            $display("FAIL pend_done: done=%b err=%b, required 1 1", o_done, o_err);
        end
        step();
    endtask

    task automatic test_flush_timeout();
        int fc;
        fc = 0;
        start_job(16'd1, 11'd3);
        n_checks++;
        if (o_err !== 1'b0) begin
            n_errors++;
            $display("FAIL err_cleared_on_start: err=%b, required 0", o_err);
        end
        step();
        pulse(1'b1, 1'b0);
        while (o_cswitch_force === 1'b1 && fc < 100) begin
            fc++;
            step();
        end
        n_checks++;
        if (fc !== 64 || o_done !== 1'b1 || o_err !== 1'b1) begin
            n_errors++;
            $display("FAIL flush_timeout: flush_cycles=%0d done=%b err=%b, required 64 1 1",
                fc, o_done, o_err);
        end
        step();
        step();
        n_checks++;
        if (o_err !== 1'b1 || o_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL err_sticky: err=%b busy=%b, required 1 0", o_err, o_busy);
        end
    endtask

    task automatic test_abort();
        int dones;
        dones = 0;
        start_job(16'd3, 11'd5);
        n_checks++;
        if (o_err !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_err_clear: err=%b, required 0", o_err);
        end
        step();
        pulse(1'b1, 1'b0);
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        n_checks++;
        if (o_clear !== 1'b1 || o_busy !== 1'b0 || o_pipeline_en !== 1'b0 ||
            o_cswitch_en !== 1'b0 || o_done !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_clear: clear=%b busy=%b pen=%b cen=%b done=%b, required 1 0 0 0 0",
                o_clear, o_busy, o_pipeline_en, o_cswitch_en, o_done);
        end
        for (int k = 0; k < 5; k++) begin
            step();
            if (o_done === 1'b1 || o_clear === 1'b1) dones++;
        end
        n_checks++;
        if (dones !== 0 || o_incntlim !== 11'd5) begin
            n_errors++;
            $display("FAIL abort_quiet: done_or_clear=%0d lim=%0d, required 0 5",
                dones, o_incntlim);
        end
        start_job(16'd1, 11'd6);
        n_checks++;
        if (o_clear !== 1'b1 || o_ctx_idx !== 16'd0 || o_incntlim !== 11'd6) begin
            n_errors++;
            $display("FAIL restart_clear: clear=%b idx=%0d lim=%0d, required 1 0 6",
                o_clear, o_ctx_idx, o_incntlim);
        end
        step();
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        n_checks++;
        if (o_done !== 1'b1 || o_ctx_idx !== 16'd1 || o_err !== 1'b0) begin
            n_errors++;
            $display("FAIL restart_done: done=%b idx=%0d err=%b, required 1 1 0",
                o_done, o_ctx_idx, o_err);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_normal_job();
        test_zero_ctx();
        test_stall();
        test_same_cycle();
        test_pend_overflow();
        test_flush_timeout();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
